// File: rtl/wishbone_arbiter_if.sv
// Wishbone classic/registered-feedback bus bundle shared by masters, arbiter and interconnect.
interface wishbone_interface;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic [3:0]  sel;
   logic        we;
   logic        stb;
   logic        cyc;
   logic        ack;
   logic [2:0]  cti;
   logic [1:0]  bte;

   modport master (
      output adr, dat_w, sel, we, stb, cyc, cti, bte,
      input  dat_r, ack
   );

   modport slave (
      input  adr, dat_w, sel, we, stb, cyc, cti, bte,
      output dat_r, ack
   );
endinterface

// File: rtl/wishbone_arbiter.sv
// Two-to-one round-robin Wishbone arbiter; a grant lasts as long as the owner holds cyc.
// Grant one cycle after cyc is seen; request forwarding and ack return are combinational.
module wishbone_arbiter #(
   parameter bit DATA_PRIORITY = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   wishbone_interface.slave  m0,
   wishbone_interface.slave  m1,
   wishbone_interface.master s,
   output logic              owner,
   output logic              locked
);
   logic last;
   logic locked_nxt;
   logic owner_nxt;
   logic last_nxt;
   logic own_cyc;
   logic own_stb;
   logic oth_req;
   logic sel1;
   logic spurious_ack;

   assign own_cyc = owner ? m1.cyc : m0.cyc;
   assign own_stb = owner ? m1.stb : m0.stb;
   assign oth_req = owner ? m0.cyc : m1.cyc;

   always_comb begin
      locked_nxt = locked;
      owner_nxt  = owner;
      last_nxt   = last;
      if (!locked) begin
         if (m0.cyc || m1.cyc) begin
            locked_nxt = 1'b1;
            owner_nxt  = (m0.cyc && m1.cyc) ? ~last : m1.cyc;
            last_nxt   = owner_nxt;
         end
      end else if (!own_cyc) begin
         // Owner released: hand straight over if the other side is waiting.
         if (oth_req) begin
            owner_nxt = ~owner;
            last_nxt  = ~owner;
         end else begin
            locked_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked <= 1'b0;
         owner  <= 1'b0;
         last   <= DATA_PRIORITY;
      end else begin
         locked <= locked_nxt;
         owner  <= owner_nxt;
         last   <= last_nxt;
      end
   end

   // Payload fields default to m0 when idle; only cyc/stb need gating.
   assign sel1    = locked & owner;
   assign s.adr   = sel1 ? m1.adr   : m0.adr;
   assign s.dat_w = sel1 ? m1.dat_w : m0.dat_w;
   assign s.sel   = sel1 ? m1.sel   : m0.sel;
   assign s.we    = sel1 ? m1.we    : m0.we;
   assign s.cti   = sel1 ? m1.cti   : m0.cti;
   assign s.bte   = sel1 ? m1.bte   : m0.bte;
   assign s.cyc   = locked & own_cyc;
   assign s.stb   = locked & own_cyc & own_stb;

   assign m0.ack   = s.ack & locked & ~owner;
   assign m1.ack   = s.ack & locked & owner;
   assign m0.dat_r = s.dat_r;
   assign m1.dat_r = s.dat_r;

   // An ack with no tenure in progress is a slave protocol violation and is dropped.
   assign spurious_ack = s.ack & ~locked;

   a_no_spurious_ack : assert property (@(posedge clk) disable iff (rst) !spurious_ack)
      else $warning("wishbone_arbiter: slave ack while bus idle");
endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: arbitration, hold, hand-off, reset and spurious ack.
module tb_wishbone_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic owner;
   logic locked;
   int   checks = 0;
   int   errors = 0;

   wishbone_interface m0_if ();
   wishbone_interface m1_if ();
   wishbone_interface s_if ();

   wishbone_arbiter #(.DATA_PRIORITY(1'b1)) dut (
      .clk    (clk),
      .rst    (rst),
      .m0     (m0_if),
      .m1     (m1_if),
      .s      (s_if),
      .owner  (owner),
      .locked (locked)
   );

   always #5 clk = ~clk;

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all;
      m0_if.adr = '0; m0_if.dat_w = '0; m0_if.sel = 4'hF; m0_if.we = 1'b0;
      m0_if.stb = 1'b0; m0_if.cyc = 1'b0; m0_if.cti = '0; m0_if.bte = '0;
      m1_if.adr = '0; m1_if.dat_w = '0; m1_if.sel = 4'hF; m1_if.we = 1'b0;
      m1_if.stb = 1'b0; m1_if.cyc = 1'b0; m1_if.cti = '0; m1_if.bte = '0;
      s_if.ack = 1'b0; s_if.dat_r = '0;
   endtask

   task automatic do_reset;
      next_cycle();
      rst = 1'b1;
      clear_all();
      next_cycle();
      next_cycle();
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset;
      clear_all();
      s_if.ack = 1'b1;
      next_cycle();
      @(negedge clk);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b want 0", locked); end
      checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b want 0", owner); end
      checks++; if (s_if.cyc !== 1'b0 || s_if.stb !== 1'b0) begin errors++; $display("FAIL rst_s_cyc_stb: got %b%b want 00", s_if.cyc, s_if.stb); end
      checks++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL rst_acks: got %b%b want 00", m0_if.ack, m1_if.ack); end
      s_if.ack = 1'b0;
      next_cycle();
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_single_read;
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h0000_1000;
      @(negedge clk);
      checks++; if (s_if.stb !== 1'b0) begin errors++; $display("FAIL sr_stb_early: got %b want 0", s_if.stb); end
      next_cycle();
      @(negedge clk);
      checks++; if (s_if.stb !== 1'b1 || s_if.cyc !== 1'b1) begin errors++; $display("FAIL sr_stb_grant: got %b%b want 11", s_if.cyc, s_if.stb); end
      checks++; if (s_if.adr !== 32'h0000_1000) begin errors++; $display("FAIL sr_adr: got %h want 00001000", s_if.adr); end
      checks++; if (locked !== 1'b1 || owner !== 1'b0) begin errors++; $display("FAIL sr_lock_owner: got %b%b want 10", locked, owner); end
      next_cycle();
      @(negedge clk);
      checks++; if (m0_if.ack !== 1'b0) begin errors++; $display("FAIL sr_ack_early: got %b want 0", m0_if.ack); end
      next_cycle();
      s_if.ack = 1'b1; s_if.dat_r = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (m0_if.ack !== 1'b1) begin errors++; $display("FAIL sr_m0_ack: got %b want 1", m0_if.ack); end
      checks++; if (m0_if.dat_r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_dat_r: got %h want deadbeef", m0_if.dat_r); end
      checks++; if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL sr_m1_ack: got %b want 0", m1_if.ack); end
      next_cycle();
      s_if.ack = 1'b0; m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
      @(negedge clk);
      checks++; if (m0_if.ack !== 1'b0) begin errors++; $display("FAIL sr_ack_single: got %b want 0", m0_if.ack); end
      checks++; if (s_if.cyc !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL sr_release_cycle: cyc %b locked %b want 0 1", s_if.cyc, locked); end
      next_cycle();
      @(negedge clk);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sr_unlock: got %b want 0", locked); end
   endtask

   task automatic test_simultaneous;
      do_reset();
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h0000_00A0;
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h0000_00B0;
      next_cycle();
      @(negedge clk);
      checks++; if (owner !== 1'b0 || s_if.adr !== 32'h0000_00A0) begin errors++; $display("FAIL sim_first: owner %b adr %h want 0 000000a0", owner, s_if.adr); end
      next_cycle();
      s_if.ack = 1'b1;
      @(negedge clk);
      checks++; if (m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL sim_ack0: got %b%b want 10", m0_if.ack, m1_if.ack); end
      next_cycle();
      s_if.ack = 1'b0; m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
      next_cycle();
      @(negedge clk);
      checks++; if (owner !== 1'b1 || s_if.adr !== 32'h0000_00B0 || s_if.stb !== 1'b1) begin errors++; $display("FAIL sim_handoff: owner %b adr %h stb %b want 1 000000b0 1", owner, s_if.adr, s_if.stb); end
      next_cycle();
      m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
      next_cycle();
      @(negedge clk);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sim_idle: got %b want 0", locked); end
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
      next_cycle();
      @(negedge clk);
      checks++; if (locked !== 1'b1 || owner !== 1'b0) begin errors++; $display("FAIL sim_second_pair: locked %b owner %b want 1 0", locked, owner); end
      next_cycle();
      clear_all();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_lr_hold;
      int held_bad;
      held_bad = 0;
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h0000_2000;
      next_cycle();
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h0000_3000;
      s_if.ack = 1'b1;
      @(negedge clk);
      checks++; if (owner !== 1'b0 || m0_if.ack !== 1'b1) begin errors++; $display("FAIL lr_read: owner %b ack %b want 0 1", owner, m0_if.ack); end
      next_cycle();
      s_if.ack = 1'b0; m0_if.stb = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (s_if.cyc !== 1'b1 || s_if.stb !== 1'b0 || owner !== 1'b0) begin
            errors++;
            $display("FAIL lr_hold_%0d: cyc %b stb %b owner %b want 1 0 0", i, s_if.cyc, s_if.stb, owner);
         end
         next_cycle();
      end
      m0_if.stb = 1'b1; m0_if.we = 1'b1; m0_if.dat_w = 32'h0000_0001;
      @(negedge clk);
      checks++; if (s_if.we !== 1'b1 || s_if.dat_w !== 32'h0000_0001 || s_if.adr !== 32'h0000_2000) begin errors++; $display("FAIL lr_sc_fwd: we %b dat %h adr %h want 1 00000001 00002000", s_if.we, s_if.dat_w, s_if.adr); end
      next_cycle();
      s_if.ack = 1'b1;
      @(negedge clk);
      checks++; if (m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL lr_sc_ack: got %b%b want 10", m0_if.ack, m1_if.ack); end
      next_cycle();
      s_if.ack = 1'b0; m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
      @(negedge clk);
      checks++; if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL lr_release: got %b want 0", s_if.cyc); end
      next_cycle();
      @(negedge clk);
      checks++; if (owner !== 1'b1 || s_if.adr !== 32'h0000_3000 || s_if.stb !== 1'b1) begin errors++; $display("FAIL lr_m1_grant: owner %b adr %h stb %b want 1 00003000 1", owner, s_if.adr, s_if.stb); end
      s_if.ack = 1'b1;
      #1;
      checks++; if (m1_if.ack !== 1'b1 || m0_if.ack !== 1'b0) begin errors++; $display("FAIL lr_m1_ack: got m1 %b m0 %b want 1 0", m1_if.ack, m0_if.ack); end
      next_cycle();
      clear_all();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_back_to_back;
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h0000_5100;
      next_cycle();
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h0000_5000;
      @(negedge clk);
      checks++; if (owner !== 1'b1 || s_if.adr !== 32'h0000_5100) begin errors++; $display("FAIL b2b_m1_owner: owner %b adr %h want 1 00005100", owner, s_if.adr); end
      next_cycle();
      m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
      @(negedge clk);
      checks++; if (s_if.cyc !== 1'b0 || s_if.stb !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b%b want 00", s_if.cyc, s_if.stb); end
      next_cycle();
      @(negedge clk);
      checks++; if (s_if.adr !== 32'h0000_5000 || owner !== 1'b0 || s_if.cyc !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL b2b_handoff: adr %h owner %b cyc %b locked %b want 00005000 0 1 1", s_if.adr, owner, s_if.cyc, locked); end
      // m0 releases in the same cycle m1 raises cyc again.
      m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h0000_5200;
      next_cycle();
      @(negedge clk);
      checks++; if (owner !== 1'b1 || s_if.adr !== 32'h0000_5200) begin errors++; $display("FAIL b2b_same_cycle: owner %b adr %h want 1 00005200", owner, s_if.adr); end
      next_cycle();
      clear_all();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_reset_mid;
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h0000_6000;
      next_cycle();
      @(negedge clk);
      checks++; if (s_if.stb !== 1'b1) begin errors++; $display("FAIL rm_pre: got %b want 1", s_if.stb); end
      next_cycle();
      rst = 1'b1;
      s_if.ack = 1'b1;
      #1;
      checks++; if (s_if.cyc !== 1'b0 || s_if.stb !== 1'b0) begin errors++; $display("FAIL rm_s_drop: got %b%b want 00", s_if.cyc, s_if.stb); end
      checks++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL rm_ack_blocked: got %b%b want 00", m0_if.ack, m1_if.ack); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rm_locked: got %b want 0", locked); end
      next_cycle();
      clear_all();
      next_cycle();
      rst = 1'b0;
      next_cycle();
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h0000_4000;
      next_cycle();
      @(negedge clk);
      checks++; if (locked !== 1'b1 || owner !== 1'b1 || s_if.adr !== 32'h0000_4000) begin errors++; $display("FAIL rm_regrant: locked %b owner %b adr %h want 1 1 00004000", locked, owner, s_if.adr); end
      next_cycle();
      clear_all();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_spurious_ack;
      s_if.ack = 1'b1;
      @(negedge clk);
      checks++; if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL sp_acks: got %b%b want 00", m0_if.ack, m1_if.ack); end
      checks++; if (dut.spurious_ack !== 1'b1) begin errors++; $display("FAIL sp_flag: got %b want 1", dut.spurious_ack); end
      next_cycle();
      s_if.ack = 1'b0;
      next_cycle();
   endtask

   initial begin
      clear_all();
      test_reset();
      test_single_read();
      test_simultaneous();
      test_lr_hold();
      test_back_to_back();
      test_reset_mid();
      test_spurious_ack();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
